cnn_sched: RTL
==============

# cnn_sched

Top-level inference sequencer for the digit-recognition CNN. It accepts a 28x28 image from the host as a valid/ready pixel stream and writes it into both redundant image-memory copies through one shared write port. It then runs the conv1 → pool1 → conv2 → pool2 → fc engines strictly in order, using one-cycle start pulses and done pulses. It also reports busy, done, error and the cycle count of the last run.

## Interface
- PIX_W, 16, pixel / image-memory data width
- N_PIX, 784, pixels per image (28x28)
- TIMEOUT_CYC, 1048576, maximum cycles any single stage may run before error
- CNT_W, 24, width of run cycle counter (saturating)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request; honoured only in IDLE
- abort  in  1  single-cycle abort; valid in any state
- pix_valid  in  1  host pixel valid
- pix_data  in  PIX_W  host pixel, row-major order
- pix_ready  out  1  high only in LOAD while pixels remain
- img_addr  out  10  write address, shared by both image-memory copies (port A)
- img_data  out  PIX_W  write data
- img_wren  out  1  write enable, both copies
- stage_start  out  5  one-hot start pulse; bit0 conv1, bit1 pool1, bit2 conv2, bit3 pool2, bit4 fc
- stage_done  in  5  one-hot done pulses from engines, same bit order
- cur_stage  out  3  state code, encoded as listed under Operation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; cleared by an accepted start
- run_cycles  out  CNT_W  cycles from start acceptance to done; saturates at all-ones

## Operation
- States and codes: IDLE=0, LOAD=1, CONV1=2, POOL1=3, CONV2=4, POOL2=5, FC=6, FLUSH=7.
- IDLE --start--> LOAD.
  - Accepting start clears error, the pixel counter and run_cycles.
- LOAD:
  - pix_ready = (pix_cnt < N_PIX).
  - Each cycle with pix_valid & pix_ready accepts one pixel and increments pix_cnt.
  - After the N_PIX-th pixel is accepted, LOAD → FLUSH.
- FLUSH: lasts exactly 1 cycle, so the last memory write commits. Then FLUSH → CONV1.
- Entering each compute state emits stage_start for that state's bit for exactly 1 cycle, on the first cycle of the state.
- Compute-state transitions:
  - The matching stage_done bit advances CONV1→POOL1→CONV2→POOL2→FC.
  - FC done → IDLE with a done pulse.
- Error conditions:
  - Any stage_done bit other than the current one, or any stage_done outside compute states → error=1, go to IDLE, no done pulse.
  - stage_cnt counts cycles in the current compute state. Reaching TIMEOUT_CYC → error=1, go to IDLE.
- abort in any non-IDLE state → IDLE. No done pulse; error is unchanged.
- Priority, highest first: abort, then the matching stage_done, then timeout, then the spurious-done error.
- start while busy is ignored. pix_valid outside LOAD is ignored.
- run_cycles increments every cycle while busy and saturates.

## Timing
- Reset values: pix_ready=0, img_addr=0, img_data=0, img_wren=0, stage_start=0, cur_stage=0, busy=0, done=0, error=0, run_cycles=0.
- Image writes are registered: img_wren/img_addr/img_data appear 1 cycle after the accepting handshake, with img_addr = index of that pixel (0..N_PIX-1).
- Last handshake at cycle t:
  - write at t+1 (FLUSH);
  - stage_start[0] at t+2.
- stage_done[i] at cycle t → next stage_start at t+1; done pulse at t+1 after FC.
- A stage_done arriving in the same cycle as that stage's stage_start is legal and is accepted.
- Asynchronous reset mid-run returns every output to its reset value immediately, with no write or pulse afterwards.

## Structure
- Shared package cnn_pkg holds:
  - the state enum (codes above);
  - the stage-bit constants STG_CONV1..STG_FC;
  - N_PIX and the image address width.
- One natural sub-module: cnn_img_loader (LOAD-side pixel counter plus registered write port), instantiated once. FSM, timeout and cycle counter stay in cnn_sched.

## Test plan
- Nominal run:
  - Stimulus: start; 784 pixels with pix_valid always high; each engine answers done 10 cycles after its start.
  - Required: writes at addresses 0..783; start pulses in order 1,2,4,8,16; a done pulse; run_cycles = 784+2+5*10 (±1 per boundary, per the cycle rules above).
- Back-pressure:
  - Stimulus: pix_valid toggles every other cycle.
  - Required: exactly 784 writes; no gaps or duplicates in addresses; pix_ready low after the 784th pixel.
- Spurious done:
  - Stimulus: stage_done=5'b00100 while in CONV1.
  - Required: error=1, cur_stage=0 next cycle, no done pulse; a new start clears error.
- Timeout:
  - Stimulus: TIMEOUT_CYC=64; pool1 never answers.
  - Required: error rises 64 cycles after stage_start[1]; FSM returns to IDLE.
- Abort and start priority:
  - Stimulus: abort asserted together with stage_done[2] in CONV2.
  - Required: IDLE, no stage_start[3], error unchanged. start during LOAD is ignored.
- Reset mid-LOAD:
  - Stimulus: rst_n low at pixel 300.
  - Required: all outputs at reset values. A subsequent run starts writing at address 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN inference sequencer.
// The state codes double as the externally visible cur_stage value.
package cnn_pkg;

    localparam int N_PIX  = 784;
    localparam int IMG_AW = 10;
    localparam int N_STG  = 5;

    localparam logic [N_STG-1:0] STG_CONV1 = 5'b00001;
    localparam logic [N_STG-1:0] STG_POOL1 = 5'b00010;
    localparam logic [N_STG-1:0] STG_CONV2 = 5'b00100;
    localparam logic [N_STG-1:0] STG_POOL2 = 5'b01000;
    localparam logic [N_STG-1:0] STG_FC    = 5'b10000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CONV1 = 3'd2,
        ST_POOL1 = 3'd3,
        ST_CONV2 = 3'd4,
        ST_POOL2 = 3'd5,
        ST_FC    = 3'd6,
        ST_FLUSH = 3'd7
    } state_e;

    // Engine bit owned by a compute state; zero for the non-compute states.
    function automatic logic [N_STG-1:0] stage_bit(state_e s);
        logic [N_STG-1:0] b;
        b = '0;
        case (s)
            ST_CONV1: b = STG_CONV1;
            ST_POOL1: b = STG_POOL1;
            ST_CONV2: b = STG_CONV2;
            ST_POOL2: b = STG_POOL2;
            ST_FC:    b = STG_FC;
            default:  b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cnn_img_loader.sv
// Counts accepted host pixels and drives the registered image-memory write port.
// Write appears one cycle after the handshake; ready drops once the image is complete.
module cnn_img_loader
    import cnn_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int NPIX  = 784
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              pix_valid_i,
    input  logic [PIX_W-1:0]  pix_data_i,
    output logic              pix_ready_o,
    output logic              last_acc_o,
    output logic [IMG_AW-1:0] img_addr_o,
    output logic [PIX_W-1:0]  img_data_o,
    output logic              img_wren_o
);

    localparam logic [IMG_AW-1:0] NPIX_C = IMG_AW'(NPIX);
    localparam logic [IMG_AW-1:0] LAST_C = IMG_AW'(NPIX - 1);

    logic [IMG_AW-1:0] pix_cnt_q, pix_cnt_d;
    logic [IMG_AW-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic              wren_q, wren_d;
    logic              acc;

    assign pix_ready_o = load_i && (pix_cnt_q < NPIX_C);
    assign acc         = pix_ready_o && pix_valid_i;
    assign last_acc_o  = acc && (pix_cnt_q == LAST_C);

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = acc;
        if (clr_i) begin
            pix_cnt_d = '0;
        end else if (acc) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end
        if (acc) begin
            addr_d = pix_cnt_q;
            data_d = pix_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
        end
    end

    assign img_addr_o = addr_q;
    assign img_data_o = data_q;
    assign img_wren_o = wren_q;

endmodule

// File: rtl/cnn_sched.sv
// Inference sequencer: image load, then conv1/pool1/conv2/pool2/fc strictly in order.
// Start pulses one cycle after the enabling event; pixel intake throttled by pix_ready.
module cnn_sched #(
    parameter int PIX_W       = 16,
    parameter int N_PIX       = 784,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int CNT_W       = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic [9:0]       img_addr,
    output logic [PIX_W-1:0] img_data,
    output logic             img_wren,
    output logic [4:0]       stage_start,
    input  logic [4:0]       stage_done,
    output logic [2:0]       cur_stage,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] run_cycles
);
    import cnn_pkg::*;

    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic             error_q, error_d;
    logic             done_q, done_d;
    logic [4:0]       stg_start_q, stg_start_d;
    logic [TW-1:0]    stage_cnt_q, stage_cnt_d;
    logic [CNT_W-1:0] run_cyc_q, run_cyc_d;

    logic       start_acc;
    logic       last_acc;
    logic       compute;
    logic [4:0] cur_bit;
    logic       match;
    logic       spurious;
    logic       timeout;

    cnn_img_loader #(
        .PIX_W (PIX_W),
        .NPIX  (N_PIX)
    ) u_loader (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start_acc),
        .load_i      (state_q == ST_LOAD),
        .pix_valid_i (pix_valid),
        .pix_data_i  (pix_data),
        .pix_ready_o (pix_ready),
        .last_acc_o  (last_acc),
        .img_addr_o  (img_addr),
        .img_data_o  (img_data),
        .img_wren_o  (img_wren)
    );

    // Outside compute states cur_bit is zero, so any done bit counts as spurious.
    assign cur_bit  = stage_bit(state_q);
    assign compute  = |cur_bit;
    assign match    = |(stage_done & cur_bit);
    assign spurious = |(stage_done & ~cur_bit);
    assign timeout  = compute && (stage_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        error_d   = error_q;
        done_d    = 1'b0;
        start_acc = 1'b0;
        if (state_q == ST_IDLE) begin
            if (spurious) begin
                error_d = 1'b1;
            end else if (start) begin
                state_d   = ST_LOAD;
                error_d   = 1'b0;
                start_acc = 1'b1;
            end
        end else if (abort) begin
            state_d = ST_IDLE;
        end else if (match) begin
            case (state_q)
                ST_CONV1: state_d = ST_POOL1;
                ST_POOL1: state_d = ST_CONV2;
                ST_CONV2: state_d = ST_POOL2;
                ST_POOL2: state_d = ST_FC;
                default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            endcase
        end else if (timeout || spurious) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
        end else if (state_q == ST_LOAD) begin
            if (last_acc) state_d = ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
            state_d = ST_CONV1;
        end
    end

    always_comb begin
        stg_start_d = '0;
        stage_cnt_d = stage_cnt_q;
        run_cyc_d   = run_cyc_q;
        if (state_d != state_q) begin
            stg_start_d = stage_bit(state_d);
            stage_cnt_d = '0;
        end else if (compute) begin
            stage_cnt_d = stage_cnt_q + 1'b1;
        end
        if (start_acc) begin
            run_cyc_d = '0;
        end else if ((state_q != ST_IDLE) && (run_cyc_q != {CNT_W{1'b1}})) begin
            run_cyc_d = run_cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            stg_start_q <= '0;
            stage_cnt_q <= '0;
            run_cyc_q   <= '0;
        end else begin
            state_q     <= state_d;
            error_q     <= error_d;
            done_q      <= done_d;
            stg_start_q <= stg_start_d;
            stage_cnt_q <= stage_cnt_d;
            run_cyc_q   <= run_cyc_d;
        end
    end

    assign stage_start = stg_start_q;
    assign cur_stage   = state_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign run_cycles  = run_cyc_q;

endmodule
